mult_sweep_checker: RTL and testbench
=====================================

MULT_SWEEP_CHECKER -- requirements
Module: mult_sweep_checker

Interface
REQ-001 Parameter WIDTH, default 2: operand width of the multiplier under test (1..8).
REQ-002 Parameter LAT, default 0: clock cycles from a_out/b_out change to a valid p_in (0..3; 0 for combinational multipliers).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  single-cycle request to begin an exhaustive sweep.
REQ-006 a_out  output  WIDTH  operand A driven to the multiplier under test.
REQ-007 b_out  output  WIDTH  operand B driven to the multiplier under test.
REQ-008 p_in  input  2*WIDTH  product returned by the multiplier under test.
REQ-009 busy  output  1  high from the cycle after an accepted start until the cycle before done.
REQ-010 done  output  1  one-cycle pulse marking the end of the sweep.
REQ-011 mismatch_count  output  2*WIDTH+1  number of operand pairs with p_in != A*B.
REQ-012 err_sum  output  4*WIDTH  sum of |p_in - A*B| over all pairs.
REQ-013 first_fail_a, first_fail_b  output  WIDTH each  operands of the first mismatching pair.
REQ-014 first_fail_valid  output  1  high once any mismatch has been recorded in the current sweep.

Function
REQ-015 The FSM has states IDLE, DRIVE, DRAIN and DONE.
REQ-016 IDLE: on start=1, clear all result outputs and the index, then go to DRIVE.
REQ-017 DRIVE: the 2*WIDTH-bit index increments each cycle; a_out = idx[WIDTH-1:0] and b_out = idx[2*WIDTH-1:WIDTH].
REQ-018 DRIVE lasts exactly 2^(2*WIDTH) cycles; on index wrap go to DRAIN if LAT>0, else DONE.
REQ-019 DRAIN lasts exactly LAT cycles, then goes to DONE.
REQ-020 DONE lasts one cycle, asserts done=1, then returns to IDLE.
REQ-021 Expected product A*B and a check-valid flag travel through a LAT-deep delay line, so each p_in is compared with the product of the operands it belongs to.
REQ-022 A compare occurs only when the delayed valid flag is 1.
REQ-023 On a mismatch, mismatch_count increments by 1 and err_sum adds the absolute difference, computed unsigned at 2*WIDTH bits.
REQ-024 The first_fail_* outputs capture the first mismatch only and hold it until the next start.
REQ-025 Results hold stable from done until the next accepted start.
REQ-026 A start received outside IDLE is ignored.
REQ-027 In IDLE, DRAIN and DONE, a_out and b_out hold 0.
REQ-028 busy=1 in DRIVE and DRAIN only; total busy cycles = 2^(2*WIDTH)+LAT.

Reset
REQ-029 rst=1 asynchronously forces IDLE, zeroes the index and delay line, and sets every output to 0, including during a sweep.
REQ-030 A sweep interrupted by reset produces no done pulse and resumes only on a new start.

Configuration
REQ-031 Macro WCE_TRACK_EN defined: add output max_err (2*WIDTH bits) holding the largest |p_in - A*B| seen in the sweep; it resets to 0 and is cleared on start.
REQ-032 Macro WCE_TRACK_EN undefined: the max_err port and its logic are absent; all other behaviour is identical.

Structure
REQ-033 A shared package holds the FSM state enum, the LAT maximum (3), and helper constants for count and sum widths derived from WIDTH.
REQ-034 The delay line is a sub-module, mult_sweep_delay, parameterized by data width and LAT; LAT=0 is a pass-through.

Verification
REQ-035 WIDTH=2, LAT=0, exact model p_in=a_out*b_out, start pulse -> busy for 16 cycles, then done; mismatch_count=0, err_sum=0, first_fail_valid=0.
REQ-036 WIDTH=2, LAT=0, p_in tied to 0 -> mismatch_count=9, err_sum=36, first_fail_a=1, first_fail_b=1, max_err=9 when WCE_TRACK_EN is defined.
REQ-037 WIDTH=2, LAT=2, exact model behind a 2-register delay -> mismatch_count=0, busy for 18 cycles; the same model with LAT=0 gives mismatch_count>0.
REQ-038 WIDTH=2, p_in=a_out*b_out+1 -> mismatch_count=16, err_sum=16, first_fail_a=0, first_fail_b=0.
REQ-039 rst=1 asserted on the 7th DRIVE cycle -> all outputs 0 immediately, no done pulse; a following start completes a normal 16-cycle sweep.
REQ-040 start pulsed again on the 5th busy cycle -> ignored; exactly one done pulse at cycle 16 with unchanged results.

Source files
------------

// File: rtl/mult_sweep_checker_pkg.sv
// Shared types and width helpers for the multiplier sweep checker.
package mult_sweep_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam int LAT_MAX = 3;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sum_w(input int w);
        return 4 * w;
    endfunction

endpackage

// File: rtl/mult_sweep_checker_delay.sv
// Fixed-depth register delay line; depth 0 is a plain wire.
module mult_sweep_delay #(
    parameter int DW  = 8,
    parameter int LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    generate
        if (LAT == 0) begin : g_wire
            assign q_o = d_i;
        end else begin : g_sr
            logic [DW-1:0] sr_q [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) sr_q[i] <= '0;
                end else begin
                    sr_q[0] <= d_i;
                    for (int i = 1; i < LAT; i++) sr_q[i] <= sr_q[i-1];
                end
            end

            assign q_o = sr_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/mult_sweep_checker.sv
// Exhaustive operand sweep and result checker for a WIDTH x WIDTH multiplier.
// Define WCE_TRACK_EN to add the max_err worst-case error output.
module mult_sweep_checker
    import mult_sweep_checker_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int LAT   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic [WIDTH-1:0]            a_out,
    output logic [WIDTH-1:0]            b_out,
    input  logic [prod_w(WIDTH)-1:0]    p_in,
    output logic                        busy,
    output logic                        done,
    output logic [cnt_w(WIDTH)-1:0]     mismatch_count,
    output logic [sum_w(WIDTH)-1:0]     err_sum,
    output logic [WIDTH-1:0]            first_fail_a,
    output logic [WIDTH-1:0]            first_fail_b,
    output logic                        first_fail_valid
`ifdef WCE_TRACK_EN
    ,
    output logic [prod_w(WIDTH)-1:0]    max_err
`endif
);

    localparam int PW    = prod_w(WIDTH);
    localparam int CW    = cnt_w(WIDTH);
    localparam int SW    = sum_w(WIDTH);
    localparam int LAT_C = (LAT > LAT_MAX) ? LAT_MAX : LAT;
    localparam int DW    = 1 + 2 * WIDTH + PW;
    localparam logic [1:0] DRAIN_LAST =
        (LAT_C > 0) ? 2'(LAT_C - 1) : 2'd0;

    state_e            state_q, state_d;
    logic [PW-1:0]     idx_q, idx_d;
    logic [1:0]        drn_q, drn_d;
    logic [CW-1:0]     mis_q, mis_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [WIDTH-1:0]  ffa_q, ffa_d;
    logic [WIDTH-1:0]  ffb_q, ffb_d;
    logic              ffv_q, ffv_d;
    logic [PW-1:0]     mx_q, mx_d;

    logic [WIDTH-1:0]  a_drv, b_drv;
    logic [PW-1:0]     prod;
    logic              chk;
    logic [DW-1:0]     dl_in, dl_out;
    logic              dv;
    logic [WIDTH-1:0]  da, db;
    logic [PW-1:0]     dp;
    logic [PW-1:0]     diff;
    logic              miss;

    assign chk   = (state_q == S_DRIVE);
    assign a_drv = chk ? idx_q[WIDTH-1:0] : '0;
    assign b_drv = chk ? idx_q[PW-1:WIDTH] : '0;
    assign prod  = {{WIDTH{1'b0}}, a_drv} * {{WIDTH{1'b0}}, b_drv};
    assign dl_in = {chk, a_drv, b_drv, prod};

    // Operands and expected product age alongside the DUT's own latency.
    mult_sweep_delay #(
        .DW  (DW),
        .LAT (LAT_C)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .d_i (dl_in),
        .q_o (dl_out)
    );

    assign {dv, da, db, dp} = dl_out;
    assign diff = (p_in >= dp) ? (p_in - dp) : (dp - p_in);
    assign miss = dv && (p_in != dp);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drn_d   = drn_q;
        mis_d   = mis_q;
        sum_d   = sum_q;
        ffa_d   = ffa_q;
        ffb_d   = ffb_q;
        ffv_d   = ffv_q;
        mx_d    = mx_q;

        if (miss) begin
            mis_d = mis_q + CW'(1);
            sum_d = sum_q + SW'(diff);
            if (diff > mx_q) mx_d = diff;
            if (!ffv_q) begin
                ffa_d = da;
                ffb_d = db;
                ffv_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    drn_d   = '0;
                    mis_d   = '0;
                    sum_d   = '0;
                    ffa_d   = '0;
                    ffb_d   = '0;
                    ffv_d   = 1'b0;
                    mx_d    = '0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                idx_d = idx_q + PW'(1);
                drn_d = '0;
                if (idx_q == '1)
                    state_d = (LAT_C > 0) ? S_DRAIN : S_DONE;
            end
            S_DRAIN: begin
                drn_d = drn_q + 2'd1;
                if (drn_q == DRAIN_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            drn_q   <= '0;
            mis_q   <= '0;
            sum_q   <= '0;
            ffa_q   <= '0;
            ffb_q   <= '0;
            ffv_q   <= 1'b0;
            mx_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drn_q   <= drn_d;
            mis_q   <= mis_d;
            sum_q   <= sum_d;
            ffa_q   <= ffa_d;
            ffb_q   <= ffb_d;
            ffv_q   <= ffv_d;
            mx_q    <= mx_d;
        end
    end

    assign a_out            = a_drv;
    assign b_out            = b_drv;
    assign busy             = (state_q == S_DRIVE) || (state_q == S_DRAIN);
    assign done             = (state_q == S_DONE);
    assign mismatch_count   = mis_q;
    assign err_sum          = sum_q;
    assign first_fail_a     = ffa_q;
    assign first_fail_b     = ffb_q;
    assign first_fail_valid = ffv_q;
`ifdef WCE_TRACK_EN
    assign max_err          = mx_q;
`else
    logic unused_mx;
    assign unused_mx = ^mx_q;
`endif

endmodule

// File: tb/tb_mult_sweep_checker.sv
// Self-checking bench: two checkers (LAT=0 and LAT=2) sweep a modelled multiplier.
module tb_mult_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   sel = 0;
    int   mode = 0;

    always #5 clk = ~clk;

    logic [1:0] a0, b0, a2, b2, ffa0, ffb0, ffa2, ffb2;
    logic [3:0] p0, p2;
    logic       busy0, done0, ffv0, busy2, done2, ffv2;
    logic [4:0] mc0, mc2;
    logic [7:0] es0, es2;
    logic [3:0] me0, me2;
    logic       start0, start2;

    assign start0 = start && (sel == 0);
    assign start2 = start && (sel != 0);

    logic [3:0] err_tab [16];
    logic [3:0] d0a = '0, d0b = '0, d2a = '0, d2b = '0;

    function automatic logic [3:0] fmod(input int m, input int a, input int b);
        logic [3:0] r;
        case (m)
            1:       r = 4'd0;
            2:       r = 4'(a * b + 1);
            3:       r = 4'(a * b + int'(err_tab[b*4+a]));
            default: r = 4'(a * b);
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        d0a <= 4'(a0 * b0);
        d0b <= d0a;
        d2a <= fmod(mode, int'(a2), int'(b2));
        d2b <= d2a;
    end

    assign p0 = (mode == 4) ? d0b : fmod(mode, int'(a0), int'(b0));
    assign p2 = d2b;

    mult_sweep_checker #(.WIDTH(2), .LAT(0)) u0 (
        .clk (clk), .rst (rst), .start (start0),
        .a_out (a0), .b_out (b0), .p_in (p0),
        .busy (busy0), .done (done0),
        .mismatch_count (mc0), .err_sum (es0),
        .first_fail_a (ffa0), .first_fail_b (ffb0),
        .first_fail_valid (ffv0)
`ifdef WCE_TRACK_EN
        , .max_err (me0)
`endif
    );

    mult_sweep_checker #(.WIDTH(2), .LAT(2)) u2 (
        .clk (clk), .rst (rst), .start (start2),
        .a_out (a2), .b_out (b2), .p_in (p2),
        .busy (busy2), .done (done2),
        .mismatch_count (mc2), .err_sum (es2),
        .first_fail_a (ffa2), .first_fail_b (ffb2),
        .first_fail_valid (ffv2)
`ifdef WCE_TRACK_EN
        , .max_err (me2)
`endif
    );

`ifndef WCE_TRACK_EN
    assign me0 = '0;
    assign me2 = '0;
`endif

    wire       s_busy = sel ? busy2 : busy0;
    wire       s_done = sel ? done2 : done0;
    wire [4:0] s_mc   = sel ? mc2 : mc0;
    wire [7:0] s_es   = sel ? es2 : es0;
    wire [1:0] s_fa   = sel ? ffa2 : ffa0;
    wire [1:0] s_fb   = sel ? ffb2 : ffb0;
    wire       s_fv   = sel ? ffv2 : ffv0;
    wire [3:0] s_me   = sel ? me2 : me0;

    int n_tests = 0;
    int n_fail  = 0;

    int busy_n, done_n, done_at;
    int r_mc, r_es, r_fa, r_fb, r_fv, r_me, h_mc, h_es;
    int x_mc, x_es, x_fa, x_fb, x_fv, x_me;

    // Reference: pair k drives a=k%4,b=k/4; the checker sees the model
    // output of the pair `shift` cycles earlier (idle operands are 0,0).
    task automatic model(input int m, input int shift);
        x_mc = 0; x_es = 0; x_fa = 0; x_fb = 0; x_fv = 0; x_me = 0;
        for (int k = 0; k < 16; k++) begin
            int a, b, e, ks, o, d;
            a = k % 4; b = k / 4; e = a * b; ks = k - shift;
            o = (ks < 0) ? int'(fmod(m, 0, 0)) : int'(fmod(m, ks % 4, ks / 4));
            if (o != e) begin
                d = (o > e) ? o - e : e - o;
                x_mc++; x_es += d;
                if (d > x_me) x_me = d;
                if (x_fv == 0) begin x_fv = 1; x_fa = a; x_fb = b; end
            end
        end
    endtask

    task automatic sweep(input int restart_at);
        busy_n = 0; done_n = 0; done_at = 0;
        r_mc = -1; r_es = -1; r_fa = -1; r_fb = -1; r_fv = -1; r_me = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (s_busy) busy_n++;
            if (s_done) begin
                done_n++; done_at = c;
                r_mc = s_mc; r_es = s_es; r_fa = s_fa;
                r_fb = s_fb; r_fv = s_fv; r_me = s_me;
            end
            start = (c == restart_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        h_mc = s_mc; h_es = s_es;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({a0, b0, busy0, done0, mc0, es0, ffv0, ffa0, ffb0} !== '0) begin
            n_fail++;
            $display("FAIL reset_u0: got %0h want 0",
                     {a0, b0, busy0, done0, mc0, es0, ffv0, ffa0, ffb0});
        end
        n_tests++;
        if ({a2, b2, busy2, done2, mc2, es2, ffv2, me0, me2} !== '0) begin
            n_fail++;
            $display("FAIL reset_u2: got %0h want 0",
                     {a2, b2, busy2, done2, mc2, es2, ffv2, me0, me2});
        end
        rst = 1'b0;
    endtask

    task automatic test_mode(input string nm, input int s, input int m,
                             input int shift, input int restart_at);
        int lat;
        sel = s; mode = m; lat = s ? 2 : 0;
        model((m == 4) ? 0 : m, shift);
        sweep(restart_at);
        n_tests++;
        if (busy_n != 16 + lat || done_n != 1 || done_at != 17 + lat) begin
            n_fail++;
            $display("FAIL %s_timing: got busy=%0d done=%0d at %0d want %0d 1 %0d",
                     nm, busy_n, done_n, done_at, 16 + lat, 17 + lat);
        end
        n_tests++;
        if (r_mc != x_mc || r_es != x_es) begin
            n_fail++;
            $display("FAIL %s_counts: got mc=%0d es=%0d want %0d %0d",
                     nm, r_mc, r_es, x_mc, x_es);
        end
        n_tests++;
        if (r_fv != x_fv || (x_fv != 0 && (r_fa != x_fa || r_fb != x_fb))) begin
            n_fail++;
            $display("FAIL %s_first: got v=%0d a=%0d b=%0d want %0d %0d %0d",
                     nm, r_fv, r_fa, r_fb, x_fv, x_fa, x_fb);
        end
        n_tests++;
        if (h_mc != x_mc || h_es != x_es) begin
            n_fail++;
            $display("FAIL %s_hold: got mc=%0d es=%0d want %0d %0d",
                     nm, h_mc, h_es, x_mc, x_es);
        end
`ifdef WCE_TRACK_EN
        n_tests++;
        if (r_me != x_me) begin
            n_fail++;
            $display("FAIL %s_maxerr: got %0d want %0d", nm, r_me, x_me);
        end
`endif
    endtask

    task automatic test_known_values;
        test_mode("exact", 0, 0, 0, 0);
        n_tests++;
        if (r_mc != 0 || r_es != 0 || r_fv != 0) begin
            n_fail++;
            $display("FAIL exact_const: got %0d %0d %0d want 0 0 0", r_mc, r_es, r_fv);
        end
        test_mode("zero", 0, 1, 0, 0);
        n_tests++;
        if (r_mc != 9 || r_es != 36 || r_fa != 1 || r_fb != 1) begin
            n_fail++;
            $display("FAIL zero_const: got %0d %0d %0d %0d want 9 36 1 1",
                     r_mc, r_es, r_fa, r_fb);
        end
        test_mode("plus1", 0, 2, 0, 0);
        n_tests++;
        if (r_mc != 16 || r_es != 16 || r_fa != 0 || r_fb != 0) begin
            n_fail++;
            $display("FAIL plus1_const: got %0d %0d %0d %0d want 16 16 0 0",
                     r_mc, r_es, r_fa, r_fb);
        end
    endtask

    task automatic test_latency;
        test_mode("lat2_exact", 1, 0, 0, 0);
        test_mode("lat0_late", 0, 4, 2, 0);
        n_tests++;
        if (r_mc == 0) begin
            n_fail++;
            $display("FAIL lat0_late_nonzero: got %0d want >0", r_mc);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 16; i++)
                err_tab[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            test_mode("rand", it % 2, 3, 0, 0);
        end
    endtask

    task automatic test_reset_mid;
        int dn;
        sel = 0; mode = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({a0, b0, busy0, done0, mc0, es0, ffv0, ffa0, ffb0, me0} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_zero: got %0h want 0",
                     {a0, b0, busy0, done0, mc0, es0, ffv0, ffa0, ffb0, me0});
        end
        @(posedge clk); #1 rst = 1'b0;
        dn = 0;
        repeat (25) begin @(posedge clk); #1; if (done0 || busy0) dn++; end
        n_tests++;
        if (dn != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", dn);
        end
        test_mode("after_reset", 0, 1, 0, 0);
    endtask

    task automatic test_back_to_back;
        test_mode("restart_ignored", 0, 2, 0, 5);
        test_mode("restart_ignored_l2", 1, 1, 0, 5);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) err_tab[i] = '0;
        test_reset;
        test_known_values;
        test_latency;
        test_random;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
